mips_multicycle_controller: RTL
===============================

MIPS_MULTICYCLE_CONTROLLER -- requirements
Module: mips_multicycle_controller

Interface
REQ-001 SHALL have parameter MEM_HANDSHAKE, default 1, meaning 1 = wait on mem_ready and 0 = memory always completes in one cycle with mem_ready ignored.
REQ-002 SHALL have parameter CNT_W, default 32, giving the width of the retired-instruction counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port opcode, input, 6 bits: IR[31:26] from the datapath instruction register.
REQ-006 SHALL have port funct, input, 6 bits: IR[5:0].
REQ-007 SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-008 SHALL have port mem_ready, input, 1 bit: the memory access completes in this cycle.
REQ-009 SHALL have outputs pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_write and alu_src_a, each 1 bit.
REQ-010 SHALL have 2-bit outputs: reg_dst (0=rt, 1=rd, 2=$31), mem_to_reg (0=ALUOut, 1=MDR, 2=PC), alu_src_b (0=B, 1=const 4, 2=sign-extended imm, 3=imm<<2) and pc_src (0=ALU, 1=ALUOut, 2=jump target, 3=reg A).
REQ-011 SHALL have output alu_opc, 3 bits: AND=000, OR=001, ADD=010, SUB=110, SLT=111.
REQ-012 SHALL have outputs halted (1 bit) and instr_count (CNT_W bits).

Function
REQ-013 SHALL be a Moore FSM with states FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, JAL, JR and HALT.
REQ-014 SHALL decode opcodes R=000000, addi=001000, slti=001010, lw=100011, sw=101011, beq=000100, j=000010 and jal=000011.
REQ-015 SHALL decode R-type funct add=100000, sub=100010, and=100100, or=100101, slt=101010 and jr=001000.
REQ-016 SHALL drive, in FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_opc=ADD and pc_src=0; pc_write and ir_write SHALL be 1 only in the cycle the access completes.
REQ-017 SHALL leave FETCH for DECODE only when the access completes, i.e. mem_ready=1 or MEM_HANDSHAKE=0.
REQ-018 SHALL compute the branch target in DECODE: alu_src_a=0, alu_src_b=3, alu_opc=ADD.
REQ-019 SHALL route DECODE by opcode: R to EXEC_R (funct jr to JR), addi/slti to EXEC_I, lw/sw to MEM_ADDR, beq to BRANCH, j to JUMP, jal to JAL, and any other opcode or R-type funct to HALT.
REQ-020 SHALL drive EXEC_R as alu_src_a=1, alu_src_b=0, alu_opc from funct; WB_R as reg_write=1, reg_dst=1, mem_to_reg=0.
REQ-021 SHALL drive EXEC_I as alu_src_a=1, alu_src_b=2, alu_opc ADD or SLT; WB_I as reg_write=1, reg_dst=0, mem_to_reg=0.
REQ-022 SHALL drive MEM_ADDR as alu_src_a=1, alu_src_b=2, ADD, then go to MEM_RD (lw) or MEM_WR (sw).
REQ-023 SHALL hold i_or_d=1 with mem_read (MEM_RD) or mem_write (MEM_WR) until the access completes; MEM_WB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=1.
REQ-024 SHALL drive BRANCH as alu_src_a=1, alu_src_b=0, SUB, pc_write_cond=1, pc_src=1; the PC updates only if zero=1.
REQ-025 SHALL drive JUMP as pc_write=1, pc_src=2; JAL as pc_write=1, pc_src=2, reg_write=1, reg_dst=2, mem_to_reg=2; JR as pc_write=1, pc_src=3.
REQ-026 SHALL give latencies including FETCH, with zero wait states: R/addi/slti 4, lw 5, sw 4, beq/j/jal/jr 3; each wait state adds one cycle.
REQ-027 SHALL return each final state (WB_R, WB_I, MEM_WB, completed MEM_WR, BRANCH, JUMP, JAL, JR) to FETCH and increment instr_count by 1 on that same edge, wrapping modulo 2^CNT_W.
REQ-028 SHALL make HALT absorbing until rst, with halted=1, all enables 0 and instr_count frozen.
REQ-029 SHALL keep every unlisted enable at 0 and every unlisted select at 0 in every state.

Reset
REQ-030 SHALL, on rst=1, immediately force state FETCH, instr_count=0 and halted=0, independent of clk.
REQ-031 SHALL, on rst mid-instruction or mid-wait, abandon the instruction without counting it; mem_write SHALL be 0 while rst=1.
REQ-032 SHALL, once rst is released, start the first fetch on the next rising edge of clk.

Structure
REQ-033 SHALL place opcode, funct, alu_opc and select-encoding constants plus the state typedef in shared package mips_mc_pkg.
REQ-034 SHALL contain one sub-module, mips_alu_decoder, a combinational funct-to-alu_opc map.

Verification
REQ-035 SHALL test add with MEM_HANDSHAKE=1 and mem_ready always 1 -> 4 cycles, WB_R reg_write=1 reg_dst=1, instr_count 0->1.
REQ-036 SHALL test lw with mem_ready low for 2 cycles in FETCH and 1 cycle in MEM_RD -> 8 cycles; ir_write pulses exactly once.
REQ-037 SHALL test beq with zero=0, then with zero=1 -> pc_write_cond=1 for 1 cycle each; 3 cycles; count +2.
REQ-038 SHALL test jal -> JAL with reg_dst=2, mem_to_reg=2, pc_src=2, all in one cycle.
REQ-039 SHALL test opcode 111111 -> HALT; halted=1 persists for 10 cycles; count frozen; rst clears it.
REQ-040 SHALL test rst asserted mid-MEM_WR with CNT_W=4 and count=15, then retire one more instruction -> count 0 after rst, 1 after the retire; no mem_write during or after rst.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes,
// R-type function codes, ALU operations and datapath select values.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEM_ADDR, MEM_RD,
    MEM_WB, MEM_WR, BRANCH, JUMP, JAL, JR, HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_REG_A  = 2'd3;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational map from R-type funct to ALU operation, flagging
// funct codes that are not arithmetic/logic operations.
module mips_alu_decoder
  import mips_mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_opc,
  output logic       funct_valid
);

  // Translate funct; unknown codes report invalid and default to ADD
  always_comb begin
    alu_opc     = ALU_ADD;
    funct_valid = 1'b1;
    case (funct)
      FN_ADD:  alu_opc = ALU_ADD;
      FN_SUB:  alu_opc = ALU_SUB;
      FN_AND:  alu_opc = ALU_AND;
      FN_OR:   alu_opc = ALU_OR;
      FN_SLT:  alu_opc = ALU_SLT;
      default: funct_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Moore-style multicycle MIPS control FSM with optional memory handshake
// and a retired-instruction counter.
module mips_multicycle_controller
  import mips_mc_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_src,
  output logic [2:0]       alu_opc,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  state_t     state, state_nxt;
  logic       retire;
  logic       mem_done;
  logic [2:0] r_alu_opc;
  logic       r_funct_valid;
  // zero is qualified by pc_write_cond in the datapath, not here
  logic       unused_zero;

  assign unused_zero = zero;
  assign mem_done    = (MEM_HANDSHAKE == 0) || mem_ready;

  mips_alu_decoder u_alu_dec (
    .funct       (funct),
    .alu_opc     (r_alu_opc),
    .funct_valid (r_funct_valid)
  );

  // State register and retired-instruction counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      instr_count <= '0;
    end else begin
      state <= state_nxt;
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

  // Next-state and control outputs per state
  always_comb begin
    state_nxt     = state;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    reg_dst       = DST_RT;
    mem_to_reg    = M2R_ALUOUT;
    alu_src_b     = SRCB_B;
    pc_src        = PCSRC_ALU;
    alu_opc       = ALU_AND;
    halted        = 1'b0;
    case (state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_opc   = ALU_ADD;
        if (mem_done) begin
          pc_write  = 1'b1;
          ir_write  = 1'b1;
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        alu_opc   = ALU_ADD;
        case (opcode)
          OP_RTYPE: begin
            if (funct == FN_JR)     state_nxt = JR;
            else if (r_funct_valid) state_nxt = EXEC_R;
            else                    state_nxt = HALT;
          end
          OP_ADDI, OP_SLTI: state_nxt = EXEC_I;
          OP_LW, OP_SW:     state_nxt = MEM_ADDR;
          OP_BEQ:           state_nxt = BRANCH;
          OP_J:             state_nxt = JUMP;
          OP_JAL:           state_nxt = JAL;
          default:          state_nxt = HALT;
        endcase
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_B;
        alu_opc   = r_alu_opc;
        state_nxt = WB_R;
      end
      WB_R: begin
        reg_write = 1'b1;
        reg_dst   = DST_RD;
        state_nxt = FETCH;
        retire    = 1'b1;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_opc   = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
        state_nxt = WB_I;
      end
      WB_I: begin
        reg_write = 1'b1;
        state_nxt = FETCH;
        retire    = 1'b1;
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_opc   = ALU_ADD;
        state_nxt = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_done) state_nxt = MEM_WB;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = M2R_MDR;
        state_nxt  = FETCH;
        retire     = 1'b1;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_done) begin
          state_nxt = FETCH;
          retire    = 1'b1;
        end
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_B;
        alu_opc       = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_src        = PCSRC_ALUOUT;
        state_nxt     = FETCH;
        retire        = 1'b1;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_src    = PCSRC_JUMP;
        state_nxt = FETCH;
        retire    = 1'b1;
      end
      JAL: begin
        pc_write   = 1'b1;
        pc_src     = PCSRC_JUMP;
        reg_write  = 1'b1;
        reg_dst    = DST_RA;
        mem_to_reg = M2R_PC;
        state_nxt  = FETCH;
        retire     = 1'b1;
      end
      JR: begin
        pc_write  = 1'b1;
        pc_src    = PCSRC_REG_A;
        state_nxt = FETCH;
        retire    = 1'b1;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_nxt = FETCH;
    endcase
  end

endmodule
